// File: rtl/ahb_mtx_input_stage.sv
// -----------------------------------------------------------------------------
// ahb_mtx_input_stage
//
// Master-side input stage of an AHB bus matrix. It watches one master's
// address phase, requests an output port from the arbiter and tracks whether
// this port currently owns a data phase on the selected output stage.
//
// If the address phase arrives while the arbiter has not granted the port,
// the address phase is captured into hold registers. The master is stalled
// (HREADYOUTS=0) until the grant arrives. While a data phase is active, the
// response of the data-phase output stage is returned to the master.
//
// Ports
//   HCLK, HRESET      clock, synchronous active-high reset
//   HSELS .. HREADYS  master-side address phase and system HREADY
//   HREADYOUTS/HRESPS ready and response returned to the master
//   HADDRI .. HMASTLOCKI
//                     address phase presented to the output stages
//   req               request to the arbiter (address phase present)
//   grant             output stage accepted this port's address this cycle
//   hready_mux        HREADY from the data-phase output stage
//   hresp_mux         HRESP from the data-phase output stage
//   data_phase        this port owns a data phase
// -----------------------------------------------------------------------------
module ahb_mtx_input_stage (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSELS,
   input  logic [31:0] HADDRS,
   input  logic [1:0]  HTRANSS,
   input  logic        HWRITES,
   input  logic [2:0]  HSIZES,
   input  logic [2:0]  HBURSTS,
   input  logic [3:0]  HPROTS,
   input  logic        HMASTLOCKS,
   input  logic        HREADYS,
   output logic        HREADYOUTS,
   output logic        HRESPS,
   output logic [31:0] HADDRI,
   output logic [1:0]  HTRANSI,
   output logic        HWRITEI,
   output logic [2:0]  HSIZEI,
   output logic [2:0]  HBURSTI,
   output logic [3:0]  HPROTI,
   output logic        HMASTLOCKI,
   output logic        req,
   input  logic        grant,
   input  logic        hready_mux,
   input  logic        hresp_mux,
   output logic        data_phase
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [1:0] TRANS_IDLE = 2'b00;

   state_t      state;
   state_t      state_nxt;
   logic        new_trans;
   logic        accept;
   logic        capture;

   logic [31:0] hold_addr;
   logic [1:0]  hold_trans;
   logic        hold_write;
   logic [2:0]  hold_size;
   logic [2:0]  hold_burst;
   logic [3:0]  hold_prot;
   logic        hold_lock;

   // Only NONSEQ and SEQ carry a transfer; BUSY and IDLE get the
   // zero-wait OKAY from the IDLE state without involving the arbiter.
   assign new_trans = HSELS & HREADYS & HTRANSS[1];

   // The port can start a new address phase when it is idle or when its
   // current data phase completes this cycle (back-to-back pipelining).
   assign accept = (state == IDLE) | ((state == DATA) & hready_mux);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_nxt = state;
      capture   = 1'b0;
      if (state == PEND) begin
         if (grant) begin
            state_nxt = DATA;
         end
      end else if (accept) begin
         if (new_trans) begin
            if (grant) begin
               state_nxt = DATA;
            end else begin
               state_nxt = PEND;
               capture   = 1'b1;
            end
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // State register and hold registers
   // -------------------------------------------------------------------------
   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The hold registers are loaded only on entry to PEND. While in PEND the
   // master inputs are ignored, so a second capture can never occur.
   // NOTE: the hold registers are cleared on reset even though they are only
   // visible in PEND; this keeps the outputs deterministic after reset.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         hold_addr  <= '0;
         hold_trans <= TRANS_IDLE;
         hold_write <= 1'b0;
         hold_size  <= '0;
         hold_burst <= '0;
         hold_prot  <= '0;
         hold_lock  <= 1'b0;
      end else if (capture) begin
         hold_addr  <= HADDRS;
         hold_trans <= HTRANSS;
         hold_write <= HWRITES;
         hold_size  <= HSIZES;
         hold_burst <= HBURSTS;
         hold_prot  <= HPROTS;
         hold_lock  <= HMASTLOCKS;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      HADDRI     = HADDRS;
      HTRANSI    = (HSELS & HREADYS) ? HTRANSS : TRANS_IDLE;
      HWRITEI    = HWRITES;
      HSIZEI     = HSIZES;
      HBURSTI    = HBURSTS;
      HPROTI     = HPROTS;
      HMASTLOCKI = HMASTLOCKS;
      HREADYOUTS = 1'b1;
      HRESPS     = 1'b0;
      data_phase = 1'b0;
      unique case (state)
         PEND: begin
            HADDRI     = hold_addr;
            HTRANSI    = hold_trans;
            HWRITEI    = hold_write;
            HSIZEI     = hold_size;
            HBURSTI    = hold_burst;
            HPROTI     = hold_prot;
            HMASTLOCKI = hold_lock;
            HREADYOUTS = 1'b0;
         end
         DATA: begin
            // Both cycles of a two-cycle ERROR response pass straight through.
            HREADYOUTS = hready_mux;
            HRESPS     = hresp_mux;
            data_phase = 1'b1;
         end
         default: begin
            HREADYOUTS = 1'b1;
         end
      endcase
   end

   assign req = (state == PEND) | new_trans;

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// -----------------------------------------------------------------------------
// tb_ahb_mtx_input_stage
//
// Directed scenarios followed by randomized traffic. A transfer-level model
// (a queue of waiting address phases plus a flag for data-phase ownership)
// predicts every output each cycle; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_ahb_mtx_input_stage;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic        lock;
   } ap_t;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSELS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic        HWRITES;
   logic [2:0]  HSIZES;
   logic [2:0]  HBURSTS;
   logic [3:0]  HPROTS;
   logic        HMASTLOCKS;
   logic        HREADYS;
   logic        HREADYOUTS;
   logic        HRESPS;
   logic [31:0] HADDRI;
   logic [1:0]  HTRANSI;
   logic        HWRITEI;
   logic [2:0]  HSIZEI;
   logic [2:0]  HBURSTI;
   logic [3:0]  HPROTI;
   logic        HMASTLOCKI;
   logic        req;
   logic        grant;
   logic        hready_mux;
   logic        hresp_mux;
   logic        data_phase;

   int n_checks = 0;
   int n_errors = 0;

   ahb_mtx_input_stage dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .HSELS      (HSELS),
      .HADDRS     (HADDRS),
      .HTRANSS    (HTRANSS),
      .HWRITES    (HWRITES),
      .HSIZES     (HSIZES),
      .HBURSTS    (HBURSTS),
      .HPROTS     (HPROTS),
      .HMASTLOCKS (HMASTLOCKS),
      .HREADYS    (HREADYS),
      .HREADYOUTS (HREADYOUTS),
      .HRESPS     (HRESPS),
      .HADDRI     (HADDRI),
      .HTRANSI    (HTRANSI),
      .HWRITEI    (HWRITEI),
      .HSIZEI     (HSIZEI),
      .HBURSTI    (HBURSTI),
      .HPROTI     (HPROTI),
      .HMASTLOCKI (HMASTLOCKI),
      .req        (req),
      .grant      (grant),
      .hready_mux (hready_mux),
      .hresp_mux  (hresp_mux),
      .data_phase (data_phase)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Transfer-level reference model
   //   pend_q  : address phases that arrived without a grant and still wait
   //   in_data : this port owns the current data phase
   // --------------------------------------------------------------------------
   ap_t pend_q[$];
   bit  in_data  = 1'b0;
   bit  model_on = 1'b0;

   function automatic ap_t master_ap();
      ap_t a;
      a.addr  = HADDRS;
      a.trans = HTRANSS;
      a.write = HWRITES;
      a.size  = HSIZES;
      a.burst = HBURSTS;
      a.prot  = HPROTS;
      a.lock  = HMASTLOCKS;
      return a;
   endfunction

   function automatic bit master_starts();
      return HSELS && HREADYS && (HTRANSS == T_NONSEQ || HTRANSS == T_SEQ);
   endfunction

   always @(posedge HCLK) begin
      if (HRESET) begin
         pend_q.delete();
         in_data  = 1'b0;
         model_on = 1'b1;
      end else if (pend_q.size() != 0) begin
         if (grant) begin
            void'(pend_q.pop_front());
            in_data = 1'b1;
         end
      end else if (!in_data || hready_mux) begin
         in_data = 1'b0;
         if (master_starts()) begin
            if (grant) in_data = 1'b1;
            else       pend_q.push_back(master_ap());
         end
      end
   end

   // One compare process: every output, every cycle, once reset has been seen.
   always @(negedge HCLK) begin
      if (model_on) begin
         ap_t exp_ap;
         bit  waiting;
         waiting = (pend_q.size() != 0);
         if (waiting) begin
            exp_ap = pend_q[0];
         end else begin
            exp_ap = master_ap();
            if (!(HSELS && HREADYS)) exp_ap.trans = T_IDLE;
         end
         check("m_req",        32'(req),        32'(waiting || master_starts()));
         check("m_hreadyout",  32'(HREADYOUTS), 32'(waiting ? 1'b0 : (in_data ? hready_mux : 1'b1)));
         check("m_hresp",      32'(HRESPS),     32'(in_data ? hresp_mux : 1'b0));
         check("m_data_phase", 32'(data_phase), 32'(in_data));
         check("m_haddri",     HADDRI,          exp_ap.addr);
         check("m_htransi",    32'(HTRANSI),    32'(exp_ap.trans));
         check("m_hwritei",    32'(HWRITEI),    32'(exp_ap.write));
         check("m_hsizei",     32'(HSIZEI),     32'(exp_ap.size));
         check("m_hbursti",    32'(HBURSTI),    32'(exp_ap.burst));
         check("m_hproti",     32'(HPROTI),     32'(exp_ap.prot));
         check("m_hmastlocki", 32'(HMASTLOCKI), 32'(exp_ap.lock));
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus helpers
   // --------------------------------------------------------------------------
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic master(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic write);
      HSELS      = sel;
      HTRANSS    = trans;
      HADDRS     = addr;
      HWRITES    = write;
      HSIZES     = 3'd2;
      HBURSTS    = 3'd0;
      HPROTS     = 4'h3;
      HMASTLOCKS = 1'b0;
   endtask

   task automatic master_idle();
      master(1'b0, T_IDLE, 32'h0, 1'b0);
   endtask

   int completions;

   initial begin
      HRESET     = 1'b1;
      HREADYS    = 1'b1;
      grant      = 1'b0;
      hready_mux = 1'b1;
      hresp_mux  = 1'b0;
      master_idle();

      // ---- Reset state ----------------------------------------------------
      step();
      @(negedge HCLK);
      check("rst_hreadyout", 32'(HREADYOUTS), 32'd1);
      check("rst_hresp",     32'(HRESPS),     32'd0);
      check("rst_req",       32'(req),        32'd0);
      check("rst_dp",        32'(data_phase), 32'd0);
      check("rst_htransi",   32'(HTRANSI),    32'(T_IDLE));

      // ---- Single NONSEQ, granted at once ----------------------------------
      step();
      HRESET = 1'b0;
      master(1'b1, T_NONSEQ, 32'h2000_0010, 1'b0);
      grant = 1'b1;
      @(negedge HCLK);
      check("single_req",    32'(req),     32'd1);
      check("single_haddri", HADDRI,       32'h2000_0010);
      step();
      master_idle();
      grant      = 1'b0;
      hready_mux = 1'b1;
      @(negedge HCLK);
      check("single_dp",     32'(data_phase), 32'd1);
      check("single_rdy",    32'(HREADYOUTS), 32'd1);
      step();
      @(negedge HCLK);
      check("single_idle_dp", 32'(data_phase), 32'd0);

      // ---- NONSEQ write stalled three cycles in PEND ------------------------
      master(1'b1, T_NONSEQ, 32'h4000_0000, 1'b1);
      @(negedge HCLK);
      check("pend_req0", 32'(req), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         // Master lines wander; the held address phase must not change.
         master(1'b1, T_IDLE, 32'hDEAD_0000 + 32'(i), 1'b0);
         grant = (i == 2);
         @(negedge HCLK);
         check("pend_rdy",    32'(HREADYOUTS), 32'd0);
         check("pend_haddri", HADDRI,          32'h4000_0000);
         check("pend_htrans", 32'(HTRANSI),    32'(T_NONSEQ));
         check("pend_write",  32'(HWRITEI),    32'd1);
         check("pend_req",    32'(req),        32'd1);
      end
      step();
      master_idle();
      grant = 1'b0;
      @(negedge HCLK);
      check("pend_then_dp", 32'(data_phase), 32'd1);
      step();

      // ---- INCR4 burst with one wait state on beat 2 -------------------------
      begin
         logic [1:0]  b_trans [6];
         logic [31:0] b_addr  [6];
         logic        b_hm    [6];
         logic        b_hs    [6];
         b_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
         b_addr  = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h10C, 32'h0};
         b_hm    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
         b_hs    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
         completions = 0;
         grant = 1'b1;
         for (int i = 0; i < 6; i++) begin
            master(1'b1, b_trans[i], b_addr[i], 1'b0);
            HBURSTS    = 3'd3;
            hready_mux = b_hm[i];
            HREADYS    = b_hs[i];
            @(negedge HCLK);
            if (data_phase && hready_mux) completions++;
            if (i == 2) begin
               check("burst_wait_req", 32'(req),        32'd0);
               check("burst_wait_rdy", 32'(HREADYOUTS), 32'd0);
            end
            step();
         end
         check("burst_beats", 32'(completions), 32'd4);
         grant   = 1'b0;
         HREADYS = 1'b1;
         master_idle();
      end

      // ---- Two-cycle ERROR response -------------------------------------------
      master(1'b1, T_NONSEQ, 32'h5000_0000, 1'b0);
      grant = 1'b1;
      step();
      master(1'b1, T_IDLE, 32'h5000_0004, 1'b0);
      grant      = 1'b0;
      HREADYS    = 1'b0;
      hready_mux = 1'b0;
      hresp_mux  = 1'b1;
      @(negedge HCLK);
      check("err1_resp", 32'(HRESPS),     32'd1);
      check("err1_rdy",  32'(HREADYOUTS), 32'd0);
      step();
      HREADYS    = 1'b1;
      hready_mux = 1'b1;
      @(negedge HCLK);
      check("err2_resp", 32'(HRESPS),     32'd1);
      check("err2_rdy",  32'(HREADYOUTS), 32'd1);
      step();
      hresp_mux = 1'b0;
      master_idle();
      @(negedge HCLK);
      check("err_idle_dp",  32'(data_phase), 32'd0);
      check("err_idle_rdy", 32'(HREADYOUTS), 32'd1);

      // ---- Reset while in PEND ---------------------------------------------------
      master(1'b1, T_NONSEQ, 32'h6000_0000, 1'b0);
      step();
      HRESET = 1'b1;
      @(negedge HCLK);
      check("rstp_pend_rdy", 32'(HREADYOUTS), 32'd0);
      step();
      HRESET = 1'b0;
      master_idle();
      @(negedge HCLK);
      check("rstp_req",    32'(req),        32'd0);
      check("rstp_rdy",    32'(HREADYOUTS), 32'd1);
      check("rstp_htrans", 32'(HTRANSI),    32'(T_IDLE));
      check("rstp_dp",     32'(data_phase), 32'd0);

      // ---- BUSY in IDLE, and stray grant -----------------------------------------
      master(1'b1, T_BUSY, 32'h7000_0000, 1'b0);
      grant = 1'b1;
      @(negedge HCLK);
      check("busy_req", 32'(req),        32'd0);
      check("busy_rdy", 32'(HREADYOUTS), 32'd1);
      step();
      grant = 1'b0;
      master_idle();
      @(negedge HCLK);
      check("stray_grant_dp", 32'(data_phase), 32'd0);

      // ---- Back-to-back: data phase ends with an ungranted NONSEQ ---------------
      master(1'b1, T_NONSEQ, 32'h3000_0000, 1'b0);
      grant = 1'b1;
      step();
      master(1'b1, T_NONSEQ, 32'h3000_1000, 1'b1);
      grant      = 1'b0;
      hready_mux = 1'b1;
      step();
      master_idle();
      @(negedge HCLK);
      check("b2b_rdy",    32'(HREADYOUTS), 32'd0);
      check("b2b_dp",     32'(data_phase), 32'd0);
      check("b2b_haddri", HADDRI,          32'h3000_1000);
      grant = 1'b1;
      step();
      grant = 1'b0;
      @(negedge HCLK);
      check("b2b_dp2", 32'(data_phase), 32'd1);
      step();

      // ---- Randomized traffic, checked by the model ---------------------------------
      for (int i = 0; i < 3000; i++) begin
         HRESET     = ($urandom_range(63) == 0);
         HSELS      = ($urandom_range(3) != 0);
         HTRANSS    = 2'($urandom_range(3));
         HADDRS     = $urandom;
         HWRITES    = 1'($urandom_range(1));
         HSIZES     = 3'($urandom_range(7));
         HBURSTS    = 3'($urandom_range(7));
         HPROTS     = 4'($urandom_range(15));
         HMASTLOCKS = 1'($urandom_range(1));
         HREADYS    = ($urandom_range(3) != 0);
         grant      = ($urandom_range(2) != 0);
         hready_mux = ($urandom_range(3) != 0);
         hresp_mux  = ($urandom_range(7) == 0);
         step();
      end

      HRESET = 1'b0;
      master_idle();
      step();
      @(negedge HCLK);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
